// File: rtl/mlb_bank_if.sv
// Port bundle for mlb_bank: write/read request side (master) and row data/status (slave).
interface mlb_bank_if #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 16,
  parameter int NUM_ROWS = 32,
  parameter int SEL_W    = 5
);
  localparam int ROW_W = LANES * DATA_W;
  localparam int CNT_W = $clog2(NUM_ROWS + 1);

  logic                clr;
  logic                wr_en;
  logic                wr_bcast;
  logic [SEL_W-1:0]    wr_sel;
  logic [ROW_W-1:0]    wr_data;
  logic                rd_en;
  logic [SEL_W-1:0]    rd_sel;
  logic [ROW_W-1:0]    rd_data;
  logic                rd_valid;
  logic                rd_miss;
  logic [NUM_ROWS-1:0] row_valid;
  logic [CNT_W-1:0]    valid_cnt;

  modport master (
    output clr, wr_en, wr_bcast, wr_sel, wr_data, rd_en, rd_sel,
    input  rd_data, rd_valid, rd_miss, row_valid, valid_cnt
  );

  modport slave (
    input  clr, wr_en, wr_bcast, wr_sel, wr_data, rd_en, rd_sel,
    output rd_data, rd_valid, rd_miss, row_valid, valid_cnt
  );
endinterface

// File: rtl/mlb_bank.sv
// Multi-level row buffer feeding PE groups: per-row valid, broadcast write, bulk clear, 1-cycle read.
// Optional MLB_BYPASS_EN: same-row read/write collision returns the new write data (write-through).
module mlb_bank #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 16,
  parameter int NUM_ROWS = 32,
  parameter int SEL_W    = 5
) (
  input logic       clk,
  input logic       rst,
  mlb_bank_if.slave bus
);
  localparam int ROW_W = LANES * DATA_W;
  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam logic [SEL_W:0] ROWS_LIM = (SEL_W + 1)'(NUM_ROWS);

  logic [ROW_W-1:0]    mem_reg [NUM_ROWS];
  logic [NUM_ROWS-1:0] row_valid_reg, row_valid_next, row_we;
  logic [CNT_W-1:0]    valid_cnt_reg, valid_cnt_next;
  logic [ROW_W-1:0]    rd_data_reg, rd_data_next;
  logic                rd_valid_reg, rd_miss_reg, rd_miss_next;
  logic                rd_in_range, rd_row_valid;

  // Out-of-range wr_sel never matches any gi, so such writes fall away here.
  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign row_we[gi] = bus.wr_en &&
                          (bus.wr_bcast || (bus.wr_sel == SEL_W'(gi)));
      assign row_valid_next[gi] = row_we[gi] || (row_valid_reg[gi] && !bus.clr);
    end
  endgenerate

  // Storage is deliberately left out of reset; row_valid gates its use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (row_we[i]) begin
        mem_reg[i] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    valid_cnt_next = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      valid_cnt_next = valid_cnt_next + CNT_W'(row_valid_next[i]);
    end
  end

  assign rd_in_range  = {1'b0, bus.rd_sel} < ROWS_LIM;
  assign rd_row_valid = rd_in_range && row_valid_reg[bus.rd_sel];

  // Without bypass the read sees pre-write/pre-clear state, i.e. read-before-write.
  always_comb begin
    rd_data_next = '0;
    rd_miss_next = 1'b1;
`ifdef MLB_BYPASS_EN
    if (rd_in_range && row_we[bus.rd_sel]) begin
      rd_data_next = bus.wr_data;
      rd_miss_next = 1'b0;
    end else if (rd_row_valid) begin
      rd_data_next = mem_reg[bus.rd_sel];
      rd_miss_next = 1'b0;
    end
`else
    if (rd_row_valid) begin
      rd_data_next = mem_reg[bus.rd_sel];
      rd_miss_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      rd_miss_reg   <= 1'b0;
      row_valid_reg <= '0;
      valid_cnt_reg <= '0;
    end else begin
      row_valid_reg <= row_valid_next;
      valid_cnt_reg <= valid_cnt_next;
      rd_valid_reg  <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_reg <= rd_data_next;
        rd_miss_reg <= rd_miss_next;
      end else begin
        rd_miss_reg <= 1'b0;
      end
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.rd_miss   = rd_miss_reg;
  assign bus.row_valid = row_valid_reg;
  assign bus.valid_cnt = valid_cnt_reg;
endmodule

// File: tb/tb_mlb_bank.sv
// Directed bench for mlb_bank: a 32-row instance for the main behaviour and a 20-row one for range edges.
module tb_mlb_bank;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mlb_bank_if #(.DATA_W(32), .LANES(16), .NUM_ROWS(32), .SEL_W(5)) bus ();
  mlb_bank_if #(.DATA_W(32), .LANES(16), .NUM_ROWS(20), .SEL_W(5)) bus20 ();

  mlb_bank #(.DATA_W(32), .LANES(16), .NUM_ROWS(32), .SEL_W(5)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mlb_bank #(.DATA_W(32), .LANES(16), .NUM_ROWS(20), .SEL_W(5)) u_dut20 (
    .clk(clk), .rst(rst), .bus(bus20)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [511:0] row5, bcast, ones, twos, row2, row19, junk, exp_col;

  initial begin
    for (int k = 0; k < 16; k++) begin
      row5[k*32 +: 32]  = 32'h0500_0000 + 32'(k);
      row2[k*32 +: 32]  = 32'h0202_0000 + 32'(k);
      row19[k*32 +: 32] = 32'h1919_0000 + 32'(k);
    end
    bcast = {16{32'hA5A5_A5A5}};
    ones  = {16{32'h1111_1111}};
    twos  = {16{32'h2222_2222}};
    junk  = {16{32'hDEAD_BEEF}};
`ifdef MLB_BYPASS_EN
    exp_col = twos;
`else
    exp_col = ones;
`endif

    bus.clr = 0; bus.wr_en = 0; bus.wr_bcast = 0; bus.wr_sel = 0; bus.wr_data = '0;
    bus20.clr = 0; bus20.wr_en = 0; bus20.wr_bcast = 0; bus20.wr_sel = 0; bus20.wr_data = '0;
    bus20.rd_en = 0; bus20.rd_sel = 0;
    // Reset held two cycles with a read request that must be swallowed.
    rst = 1; bus.rd_en = 1; bus.rd_sel = 3;
    step(); step();
    check("rst_rd_data", bus.rd_data, '0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_miss", bus.rd_miss, 0);
    check("rst_row_valid", bus.row_valid, 0);
    check("rst_valid_cnt", bus.valid_cnt, 0);

    rst = 0;
    step();
    check("t1_valid", bus.rd_valid, 1);
    check("t1_miss", bus.rd_miss, 1);
    check("t1_data", bus.rd_data, '0);

    // Single-row write then read.
    bus.rd_en = 0; bus.wr_en = 1; bus.wr_sel = 5; bus.wr_data = row5;
    step();
    bus.wr_en = 0; bus.rd_en = 1; bus.rd_sel = 5;
    step();
    check("t2_data", bus.rd_data, row5);
    check("t2_miss", bus.rd_miss, 0);
    check("t2_valid", bus.rd_valid, 1);
    check("t2_cnt", bus.valid_cnt, 1);
    check("t2_row_valid", bus.row_valid, 32'h0000_0020);
    bus.rd_en = 0;
    step();
    check("t2_idle_valid", bus.rd_valid, 0);
    check("t2_idle_miss", bus.rd_miss, 0);
    check("t2_idle_hold", bus.rd_data, row5);

    // Broadcast write, then read first and last rows back to back.
    bus.wr_en = 1; bus.wr_bcast = 1; bus.wr_sel = 9; bus.wr_data = bcast;
    step();
    bus.wr_en = 0; bus.wr_bcast = 0; bus.rd_en = 1; bus.rd_sel = 0;
    step();
    check("t3_row0", bus.rd_data, bcast);
    check("t3_cnt", bus.valid_cnt, 32);
    bus.rd_sel = 31;
    step();
    check("t3_row31", bus.rd_data, bcast);
    check("t3_miss", bus.rd_miss, 0);
    check("t3_row_valid", bus.row_valid, 32'hFFFF_FFFF);

    // Same-row read/write collision.
    bus.rd_en = 0; bus.wr_en = 1; bus.wr_sel = 7; bus.wr_data = ones;
    step();
    bus.wr_data = twos; bus.rd_en = 1; bus.rd_sel = 7;
    step();
    check("t4_collide", bus.rd_data, exp_col);
    check("t4_miss", bus.rd_miss, 0);
    bus.wr_en = 0;
    step();
    check("t4_after", bus.rd_data, twos);

    // Clear together with a write; then a read issued with clr sees pre-clear state.
    bus.rd_en = 0; bus.clr = 1; bus.wr_en = 1; bus.wr_sel = 2; bus.wr_data = row2;
    step();
    bus.clr = 0; bus.wr_en = 0;
    check("t5_row_valid", bus.row_valid, 32'h0000_0004);
    check("t5_cnt", bus.valid_cnt, 1);
    bus.rd_en = 1; bus.rd_sel = 5;
    step();
    check("t5_miss", bus.rd_miss, 1);
    check("t5_miss_data", bus.rd_data, '0);
    bus.clr = 1; bus.rd_sel = 2;
    step();
    bus.clr = 0; bus.rd_en = 0;
    check("t5_preclr_miss", bus.rd_miss, 0);
    check("t5_preclr_data", bus.rd_data, row2);
    check("t5_clr_rv", bus.row_valid, 0);
    check("t5_clr_cnt", bus.valid_cnt, 0);

    // 20-row instance: out-of-range write/read, then reset mid read stream.
    bus20.wr_en = 1; bus20.wr_sel = 19; bus20.wr_data = row19;
    step();
    bus20.wr_sel = 25; bus20.wr_data = junk; bus20.rd_en = 1; bus20.rd_sel = 25;
    step();
    check("t6_row_valid", bus20.row_valid, 20'h8_0000);
    check("t6_cnt", bus20.valid_cnt, 1);
    check("t6_oor_miss", bus20.rd_miss, 1);
    check("t6_oor_data", bus20.rd_data, '0);
    bus20.wr_en = 0; bus20.rd_sel = 19;
    step();
    check("t6_row19", bus20.rd_data, row19);
    check("t6_row19_miss", bus20.rd_miss, 0);
    step();
    check("t6_stream_val", bus20.rd_valid, 1);
    rst = 1;
    step();
    check("t6_rst_valid", bus20.rd_valid, 0);
    check("t6_rst_data", bus20.rd_data, '0);
    check("t6_rst_rv", bus20.row_valid, 0);
    rst = 0; bus20.rd_en = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
